// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a 3-column shift window.
// Pixel captured at edge T is visible at pixel_out9 after edge T+2.
module window_3x3_gen #(
    parameter int H_ACTIVE = 640,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              de,
    output logic [DATA_W-1:0] pixel_out1,
    output logic [DATA_W-1:0] pixel_out2,
    output logic [DATA_W-1:0] pixel_out3,
    output logic [DATA_W-1:0] pixel_out4,
    output logic [DATA_W-1:0] pixel_out5,
    output logic [DATA_W-1:0] pixel_out6,
    output logic [DATA_W-1:0] pixel_out7,
    output logic [DATA_W-1:0] pixel_out8,
    output logic [DATA_W-1:0] pixel_out9,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out,
    output logic              line_overflow
);
    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    // one extra bit so columns past the line buffer depth stay distinguishable
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COL_MAX = '1;
    localparam logic [CW-1:0] H_LIM   = CW'(H_ACTIVE);

    logic [DATA_W-1:0] ram0 [H_ACTIVE];
    logic [DATA_W-1:0] ram1 [H_ACTIVE];

    logic              de_prev_q, vs_prev_q;
    logic              sel_q, sel_d;
    logic [CW-1:0]     col_q, col_d;
    logic [1:0]        line_cnt_q, line_cnt_d;
    logic              vs_rise, de_fall, in_range, wr_en;
    logic [1:0]        line_eff;
    logic [AW-1:0]     addr;

    logic              s1_de_q, s1_hs_q, s1_vs_q, s1_ovf_q, s1_mid_ok_q, s1_top_ok_q;
    logic [DATA_W-1:0] s1_pix_q, rd_mid_q, rd_top_q;

    logic              s2_de_q, s2_hs_q, s2_vs_q, s2_ovf_q;
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];

    logic [DATA_W-1:0] out_q [9];
    logic [DATA_W-1:0] out_d [9];
    logic              hs_out_q, vs_out_q, de_out_q;
    logic              ovf_flag_q, ovf_flag_d;

    // Column/line bookkeeping; a frame start clears the line count before this pixel uses it.
    // sel_q names the RAM holding the previous line; the other holds the line before that
    // and is overwritten by the current line as it is read out.
    always_comb begin
        vs_rise    = vsync & ~vs_prev_q;
        de_fall    = ~de & de_prev_q;
        line_eff   = vs_rise ? 2'd0 : line_cnt_q;
        in_range   = (col_q < H_LIM);
        wr_en      = de & in_range;
        addr       = in_range ? col_q[AW-1:0] : '0;
        col_d      = col_q;
        line_cnt_d = line_eff;
        sel_d      = sel_q;
        if (de) begin
            if (col_q != COL_MAX) col_d = col_q + 1'b1;
        end else if (de_fall) begin
            col_d = '0;
            sel_d = ~sel_q;
            if (line_eff != 2'd2) line_cnt_d = line_eff + 2'd1;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            sel_q      <= 1'b0;
            col_q      <= '0;
            line_cnt_q <= 2'd0;
        end else begin
            de_prev_q  <= de;
            vs_prev_q  <= vsync;
            sel_q      <= sel_d;
            col_q      <= col_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Line buffers: synchronous read of both lines, read-before-write on the same address.
    always_ff @(posedge clk) begin
        if (sel_q) begin
            rd_mid_q <= ram1[addr];
            rd_top_q <= ram0[addr];
        end else begin
            rd_mid_q <= ram0[addr];
            rd_top_q <= ram1[addr];
        end
        if (wr_en) begin
            if (sel_q) ram0[addr] <= pixel_in;
            else       ram1[addr] <= pixel_in;
        end
    end

    // Stage 1: capture pixel, syncs, and whether the RAM rows may be shown (masks stale data).
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_de_q     <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            s1_pix_q    <= '0;
            s1_ovf_q    <= 1'b0;
            s1_mid_ok_q <= 1'b0;
            s1_top_ok_q <= 1'b0;
        end else begin
            s1_de_q     <= de;
            s1_hs_q     <= hsync;
            s1_vs_q     <= vsync;
            s1_pix_q    <= de ? pixel_in : '0;
            s1_ovf_q    <= de & ~in_range;
            s1_mid_ok_q <= wr_en & (line_eff != 2'd0);
            s1_top_ok_q <= wr_en & (line_eff == 2'd2);
        end
    end

    // Window shift (row-major, newest column at index 2/5/8); cleared between lines for the left border.
    always_comb begin
        for (int i = 0; i < 9; i++) win_d[i] = '0;
        if (s1_de_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = s1_top_ok_q ? rd_top_q : '0;
            win_d[5] = s1_mid_ok_q ? rd_mid_q : '0;
            win_d[8] = s1_pix_q;
        end
    end

    // Stage 2: window and delayed syncs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
            s2_de_q  <= 1'b0;
            s2_hs_q  <= 1'b0;
            s2_vs_q  <= 1'b0;
            s2_ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
            s2_de_q  <= s1_de_q;
            s2_hs_q  <= s1_hs_q;
            s2_vs_q  <= s1_vs_q;
            s2_ovf_q <= s1_ovf_q;
        end
    end

    // Output gating and sticky overflow; an overflowing pixel reaching the output wins over a frame clear.
    always_comb begin
        for (int i = 0; i < 9; i++) out_d[i] = s2_de_q ? win_q[i] : '0;
        ovf_flag_d = ovf_flag_q;
        if (vs_rise) ovf_flag_d = 1'b0;
        if (s2_de_q && s2_ovf_q) ovf_flag_d = 1'b1;
    end

    // Stage 3: output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) out_q[i] <= '0;
            hs_out_q   <= 1'b0;
            vs_out_q   <= 1'b0;
            de_out_q   <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) out_q[i] <= out_d[i];
            hs_out_q   <= s2_hs_q;
            vs_out_q   <= s2_vs_q;
            de_out_q   <= s2_de_q;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    assign pixel_out1    = out_q[0];
    assign pixel_out2    = out_q[1];
    assign pixel_out3    = out_q[2];
    assign pixel_out4    = out_q[3];
    assign pixel_out5    = out_q[4];
    assign pixel_out6    = out_q[5];
    assign pixel_out7    = out_q[6];
    assign pixel_out8    = out_q[7];
    assign pixel_out9    = out_q[8];
    assign hsync_out     = hs_out_q;
    assign vsync_out     = vs_out_q;
    assign de_out        = de_out_q;
    assign line_overflow = ovf_flag_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: per-column reference of the current frame, compared every cycle,
// plus hand-computed pinned windows.
module tb_window_3x3_gen;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, hsync, vsync, de;
    logic [DW-1:0] pixel_in;
    logic [DW-1:0] po1, po2, po3, po4, po5, po6, po7, po8, po9;
    logic          hs_o, vs_o, de_o, ovf_o;

    always #5 clk = ~clk;

    window_3x3_gen #(.H_ACTIVE(H), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .hsync(hsync), .vsync(vsync), .de(de),
        .pixel_out1(po1), .pixel_out2(po2), .pixel_out3(po3),
        .pixel_out4(po4), .pixel_out5(po5), .pixel_out6(po6),
        .pixel_out7(po7), .pixel_out8(po8), .pixel_out9(po9),
        .hsync_out(hs_o), .vsync_out(vs_o), .de_out(de_o), .line_overflow(ovf_o)
    );

    wire [75:0] dut_vec = {po1, po2, po3, po4, po5, po6, po7, po8, po9, de_o, hs_o, vs_o, ovf_o};

    typedef struct packed {
        logic [0:8][7:0] px;
        logic            de;
        logic            hs;
        logic            vs;
        logic            ovf;
    } rec_t;

    // reference model state
    int         m_col, m_lines;
    logic       m_vs_prev, m_de_prev, eflag;
    logic [7:0] prev1 [H];
    logic [7:0] prev2 [H];
    logic [7:0] ct [64];
    logic [7:0] cm [64];
    logic [7:0] cb [64];
    rec_t       h1, h2, eout;

    int         n_checks = 0, n_pass = 0, cyc = 0, nlit = 0;
    int         lit_at  [32];
    logic [75:0] lit_val [32];
    string      lit_nm  [32];

    function automatic logic [75:0] model_vec();
        return {eout.px, eout.de, eout.hs, eout.vs, eflag};
    endfunction

    function automatic logic [75:0] lv(input logic [7:0] a, b, c, d, e, f, g, h, i,
                                       input logic de_, hs_, vs_, fl);
        return {a, b, c, d, e, f, g, h, i, de_, hs_, vs_, fl};
    endfunction

    task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic add_lit(input int ofs, input string nm, input logic [75:0] v);
        lit_at[nlit]  = cyc + ofs;
        lit_val[nlit] = v;
        lit_nm[nlit]  = nm;
        nlit++;
    endtask

    // Expected outputs after this edge, from the window definition over the frame seen so far.
    task automatic model_step(input logic r, input logic d, input logic [7:0] p,
                              input logic hs, input logic vs);
        rec_t e;
        logic vr;
        int   c;
        if (!r) begin
            m_col = 0; m_lines = 0; m_vs_prev = 0; m_de_prev = 0;
            h1 = '0; h2 = '0; eout = '0; eflag = 0;
            return;
        end
        e = '0; e.de = d; e.hs = hs; e.vs = vs;
        vr = vs && !m_vs_prev;
        m_vs_prev = vs;
        if (vr) begin m_lines = 0; eflag = 0; end
        if (d) begin
            cb[m_col] = p;
            cm[m_col] = (m_col < H && m_lines >= 1) ? prev1[m_col] : 8'h00;
            ct[m_col] = (m_col < H && m_lines == 2) ? prev2[m_col] : 8'h00;
            for (int k = 0; k < 3; k++) begin
                c = m_col - 2 + k;
                if (c >= 0) begin
                    e.px[k]   = ct[c];
                    e.px[3+k] = cm[c];
                    e.px[6+k] = cb[c];
                end
            end
            e.ovf = (m_col >= H);
            if (m_col < 63) m_col++;
        end else if (m_de_prev) begin
            for (int k = 0; k < H; k++) begin
                prev2[k] = prev1[k];
                prev1[k] = cb[k];
            end
            if (m_lines < 2) m_lines++;
            m_col = 0;
        end
        m_de_prev = d;
        eout = h2; h2 = h1; h1 = e;
        if (eout.de && eout.ovf) eflag = 1;
    endtask

    task automatic step(input logic r, input logic d, input logic [7:0] p,
                        input logic hs, input logic vs);
        rst = r; de = d; pixel_in = p; hsync = hs; vsync = vs;
        model_step(r, d, p, hs, vs);
        @(posedge clk);
        #1;
        chk($sformatf("cycle%0d", cyc), dut_vec, model_vec());
        for (int i = 0; i < nlit; i++) begin
            if (lit_at[i] == cyc) begin
                chk({lit_nm[i], "_dut"}, dut_vec, lit_val[i]);
                chk({lit_nm[i], "_model"}, model_vec(), lit_val[i]);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int nl, len, nb;
        logic vsf, rr;

        // reset with activity on the inputs
        for (int i = 0; i < 3; i++) step(0, 1'(i % 2), 8'(i + 5), 1'((i + 1) % 2), 0);
        add_lit(0, "after_release", '0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // frame A: pixel = 16*row + col
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int row = 0; row < 3; row++) begin
            for (int x = 0; x < H; x++) begin
                if (row == 0 && x == 0)
                    add_lit(2, "p00", lv(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0));
                if (row == 0 && x == 1)
                    add_lit(2, "p01", lv(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0, 0, 0));
                if (row == 2 && x == 2)
                    add_lit(2, "p22", lv(8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12,
                                         8'h20, 8'h21, 8'h22, 1, 0, 0, 0));
                step(1, 1, 8'(16 * row + x), 0, 0);
            end
            step(1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // single-cycle hsync in blanking
        add_lit(1, "hs_early", '0);
        add_lit(2, "hs_late", lv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // frame B: stale RAM must be masked, then an overlong line
        add_lit(2, "vs_late", lv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int x = 0; x < H; x++) begin
            if (x == 2)
                add_lit(2, "stale_mask", lv(0, 0, 0, 0, 0, 0, 8'hAA, 8'hAA, 8'hAA, 1, 0, 0, 0));
            step(1, 1, 8'hAA, 0, 0);
        end
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int x = 0; x < 6; x++) begin
            if (x == 4)
                add_lit(2, "ovf_px", lv(0, 0, 0, 8'hAA, 8'hAA, 8'h00, 8'hB2, 8'hB3, 8'hB4,
                                        1, 0, 0, 1));
            step(1, 1, 8'(8'hB0 + x), 0, 0);
        end
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        add_lit(0, "ovf_held", lv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step(1, 0, 0, 0, 0);
        add_lit(0, "ovf_cleared", '0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);

        // reset in the middle of a line, then a fresh frame
        step(1, 1, 8'h55, 0, 0);
        step(1, 1, 8'h56, 0, 0);
        step(0, 1, 8'h57, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            step(1, 0, 0, 1'($urandom_range(0, 1)), 1);
            if ($urandom_range(0, 1) == 1) step(1, 0, 0, 0, 1);
            step(1, 0, 0, 0, 0);
            nl = 3 + $urandom_range(0, 2);
            for (int l = 0; l < nl; l++) begin
                len = H + $urandom_range(0, 2);
                vsf = ($urandom_range(0, 5) == 0);
                for (int x = 0; x < len; x++)
                    step(1, 1, 8'($urandom), 1'($urandom_range(0, 1)), vsf && (x == 0));
                nb = 1 + $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    rr = ($urandom_range(0, 19) != 0);
                    step(rr, 0, 8'($urandom), 1'($urandom_range(0, 1)), 0);
                end
            end
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
